mux_sel_ctrl: RTL and testbench

Upstream control stage for the 2:1 mux: conditions the raw pin inputs before they reach the mux datapath. Synchronises all pin inputs and debounces the select pin. Provides an optional auto-toggle mode in which the select alternates at a programmable period. Outputs sel/in0/in1 feed the mux directly; a change strobe and a toggle counter are provided for status outputs.

---
 rtl/mux_pkg.sv | 14 +
 rtl/sync2.sv | 23 ++
 rtl/mux_sel_ctrl.sv | 125 ++++++++++++
 tb/tb_mux_sel_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the mux select control stage.
package mux_pkg;

  typedef enum logic [1:0] {
    STABLE   = 2'd0,
    DEBOUNCE = 2'd1,
    AUTO     = 2'd2
  } sel_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PERIOD_W_DEF        = 8;
  localparam int DB_W                = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser, parameterised width, sync active-high reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_sel_ctrl.sv
// Pin conditioning for the 2:1 mux: sync, select debounce, auto-toggle.
module mux_sel_ctrl
  import mux_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PERIOD_W        = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_sel,
  input  logic                raw_in0,
  input  logic                raw_in1,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                sel,
  output logic                in0,
  output logic                in1,
  output logic                sel_chg,
  output logic [7:0]          toggle_cnt
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync_q;
  logic       sel_s;
  logic       auto_s;

  sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({auto_en, raw_in1, raw_in0, raw_sel}),
    .q   (sync_q)
  );

  assign sel_s  = sync_q[0];
  assign in0    = sync_q[1];
  assign in1    = sync_q[2];
  assign auto_s = sync_q[3];

  sel_state_e          state, state_n;
  logic [DB_W-1:0]     db_cnt, db_n;
  logic [PERIOD_W-1:0] per_cnt, per_n;
  logic                sel_n;
  logic                chg_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE;
      db_cnt     <= '0;
      per_cnt    <= '0;
      sel        <= 1'b0;
      sel_chg    <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      state      <= state_n;
      db_cnt     <= db_n;
      per_cnt    <= per_n;
      sel        <= sel_n;
      sel_chg    <= chg_n;
      toggle_cnt <= toggle_cnt + {7'd0, chg_n};
    end
  end

  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    per_n   = per_cnt;
    sel_n   = sel;
    chg_n   = 1'b0;
    unique case (state)
      STABLE: begin
        if (auto_s) begin
          state_n = AUTO;
          per_n   = '0;
        end else if (sel_s != sel) begin
          if (DEBOUNCE_CYCLES == 1) begin
            sel_n = ~sel;
            chg_n = 1'b1;
          end else begin
            state_n = DEBOUNCE;
            db_n    = DB_W'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (auto_s) begin
          state_n = AUTO;
          per_n   = '0;
          db_n    = '0;
        end else if (sel_s == sel) begin
          state_n = STABLE;
          db_n    = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n = STABLE;
          db_n    = '0;
          sel_n   = ~sel;
          chg_n   = 1'b1;
        end else begin
          db_n = db_cnt + DB_W'(1);
        end
      end
      AUTO: begin
        if (!auto_s) begin
          state_n = STABLE;
          per_n   = '0;
        end else if (period == '0) begin
          per_n = '0;
        end else if (per_cnt == period - PERIOD_W'(1)) begin
          // wraps through 2^PERIOD_W if period shrank below the count
          per_n = '0;
          sel_n = ~sel;
          chg_n = 1'b1;
        end else begin
          per_n = per_cnt + PERIOD_W'(1);
        end
      end
      default: begin
        state_n = STABLE;
        db_n    = '0;
        per_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Randomised and directed bench for mux_sel_ctrl against a rule-level model.
module tb_mux_sel_ctrl;

  localparam int DC = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          raw_sel, raw_in0, raw_in1, auto_en;
  logic [PW-1:0] period;
  logic          sel, in0, in1, sel_chg;
  logic [7:0]    toggle_cnt;

  int checks = 0;
  int errors = 0;

  mux_sel_ctrl #(.DEBOUNCE_CYCLES(DC), .PERIOD_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_sel    (raw_sel),
    .raw_in0    (raw_in0),
    .raw_in1    (raw_in1),
    .auto_en    (auto_en),
    .period     (period),
    .sel        (sel),
    .in0        (in0),
    .in1        (in1),
    .sel_chg    (sel_chg),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  // model: pin history, mode flag, mismatch run length, auto elapsed time
  bit [3:0] m_s1, m_s2;
  bit       m_sel, m_chg, m_auto;
  int       m_run, m_el, m_tc;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic flip();
    m_sel = !m_sel;
    m_chg = 1'b1;
    m_tc  = (m_tc + 1) % 256;
  endtask

  task automatic tick();
    bit ss, as;
    @(posedge clk);
    ss    = m_s2[0];
    as    = m_s2[3];
    m_chg = 1'b0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0;
      m_sel = 0; m_auto = 0;
      m_run = 0; m_el = 0; m_tc = 0;
    end else begin
      if (!m_auto) begin
        if (as) begin
          m_auto = 1; m_el = 0; m_run = 0;
        end else begin
          m_run = (ss != m_sel) ? m_run + 1 : 0;
          if (m_run == DC) begin
            flip();
            m_run = 0;
          end
        end
      end else if (!as) begin
        m_auto = 0; m_run = 0;
      end else if (period == 0) begin
        m_el = 0;
      end else begin
        m_el++;
        if (m_el == int'(period)) begin
          flip();
          m_el = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {auto_en, raw_in1, raw_in0, raw_sel};
    end
    #1;
    chk("sel", sel, m_sel);
    chk("in0", in0, m_s2[1]);
    chk("in1", in1, m_s2[2]);
    chk("sel_chg", sel_chg, m_chg);
    chk("toggle_cnt", toggle_cnt, m_tc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int low_cnt;
    int start_sel;
    rst = 1'b1; raw_sel = 0; raw_in0 = 0; raw_in1 = 0;
    auto_en = 0; period = 8'd3;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_tc", toggle_cnt, 0);
    rst = 1'b0;
    tick();

    // clean step: flip exactly 6 edges later
    raw_sel = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) chk("s1_pre", sel, 0);
      if (i == 6) chk("s1_lat6", sel_chg, 1);
      if (i == 7) chk("s1_pulse_end", sel_chg, 0);
    end
    chk("s1_tc", toggle_cnt, 1);

    // bounce rejected, then 4-cycle pulse accepted
    do_reset();
    raw_sel = 0;
    tick(); tick();
    raw_sel = 1; repeat (3) tick();
    raw_sel = 0; repeat (8) tick();
    chk("s2_bounce_sel", sel, 0);
    chk("s2_bounce_tc", toggle_cnt, 0);
    raw_sel = 1; repeat (4) tick();
    raw_sel = 0; repeat (3) tick();
    chk("s2_accept", sel, 1);
    repeat (8) tick();

    // auto mode period 3, then frozen with period 0
    do_reset();
    raw_sel = 0; period = 8'd3; auto_en = 1;
    repeat (3) tick();
    repeat (18) tick();
    chk("s3_tc6", toggle_cnt, 6);
    period = 8'd0;
    start_sel = sel;
    repeat (10) tick();
    chk("s3_frozen", sel, start_sel);
    auto_en = 0; repeat (12) tick();

    // auto request arrives mid-debounce
    do_reset();
    period = 8'd5;
    raw_sel = 1; tick(); tick();
    auto_en = 1;
    repeat (12) tick();
    auto_en = 0; raw_sel = sel; repeat (12) tick();

    // reset mid-auto
    do_reset();
    raw_sel = 0; period = 8'd2; auto_en = 1;
    repeat (13) tick();
    rst = 1'b1; tick();
    chk("s5_sel", sel, 0);
    chk("s5_tc", toggle_cnt, 0);
    rst = 1'b0; auto_en = 0; raw_in0 = 1;
    tick();
    chk("s5_in0_early", in0, 0);
    tick();
    chk("s5_in0", in0, 1);

    // 256 toggles wrap the counter
    do_reset();
    raw_in0 = 0; period = 8'd1; auto_en = 1;
    repeat (3) tick();
    start_sel = sel;
    repeat (256) tick();
    chk("s6_wrap_tc", toggle_cnt, 0);
    chk("s6_wrap_sel", sel, start_sel);
    auto_en = 0; repeat (6) tick();

    // random phase; period only changes after auto has been low a while
    low_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) raw_sel = ~raw_sel;
      if ($urandom_range(0, 99) < 30) raw_in0 = ~raw_in0;
      if ($urandom_range(0, 99) < 30) raw_in1 = ~raw_in1;
      if ($urandom_range(0, 99) < 2)  auto_en = ~auto_en;
      low_cnt = auto_en ? 0 : low_cnt + 1;
      if (low_cnt > 4 && $urandom_range(0, 99) < 10)
        period = PW'($urandom_range(0, 6));
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
